// File: rtl/mem_rd_skew_ctrl.sv
// Read sequencer for the per-lane input memory: lane 0 walks base_addr..base_addr+N-1,
// and every other lane replays its neighbour one cycle later to form the systolic skew.
module mem_rd_skew_ctrl #(
  parameter int width_height = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [7:0]                  base_addr,
  input  logic [7:0]                  num_rows,
  output logic [width_height-1:0]     rd_en,
  output logic [width_height*8-1:0]   rd_addr,
  output logic [width_height-1:0]     rd_valid,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  dbg_state
);

  // Handshake: start is a one-cycle request, honoured only while IDLE; busy/done report progress.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [7:0]              row_cnt, row_cnt_nx;
  logic [7:0]              num_rows_q, num_rows_q_nx;
  logic                    en0_nx;
  logic [7:0]              addr0_nx;
  logic                    last0_nx;
  logic                    done_nx;
  logic                    busy_nx;
  logic [width_height-1:0] last_q;
  logic [7:0]              lane_addr [width_height];

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && (num_rows != 8'd0)) state_nx = ISSUE;
      ISSUE:   if (row_cnt == num_rows_q)       state_nx = DRAIN;
      DRAIN:   if (done)                        state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values for lane 0 and the status flags
  always_comb begin
    en0_nx        = 1'b0;
    addr0_nx      = lane_addr[0];
    last0_nx      = 1'b0;
    row_cnt_nx    = row_cnt;
    num_rows_q_nx = num_rows_q;
    done_nx       = 1'b0;
    busy_nx       = (state_nx != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          if (num_rows != 8'd0) begin
            en0_nx        = 1'b1;
            addr0_nx      = base_addr;
            row_cnt_nx    = 8'd1;
            num_rows_q_nx = num_rows;
            last0_nx      = (num_rows == 8'd1);
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (row_cnt != num_rows_q) begin
          en0_nx     = 1'b1;
          addr0_nx   = lane_addr[0] + 8'd1;
          row_cnt_nx = row_cnt + 8'd1;
          last0_nx   = ((row_cnt + 8'd1) == num_rows_q);
        end
      end
      DRAIN: begin
        // last_q marks the final enabled row; the matching rd_valid is one cycle later.
        done_nx = last_q[width_height-1];
        if (done) row_cnt_nx = 8'd0;
      end
      default: ;
    endcase
  end

  // Lane shift registers and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en      <= '0;
      rd_valid   <= '0;
      last_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      row_cnt    <= 8'd0;
      num_rows_q <= 8'd0;
      for (int i = 0; i < width_height; i++) lane_addr[i] <= 8'd0;
    end else begin
      rd_en[0]     <= en0_nx;
      lane_addr[0] <= addr0_nx;
      last_q[0]    <= last0_nx;
      for (int i = 1; i < width_height; i++) begin
        rd_en[i]     <= rd_en[i-1];
        lane_addr[i] <= lane_addr[i-1];
        last_q[i]    <= last_q[i-1];
      end
      rd_valid   <= rd_en;
      busy       <= busy_nx;
      done       <= done_nx;
      row_cnt    <= row_cnt_nx;
      num_rows_q <= num_rows_q_nx;
    end
  end

  for (genvar g = 0; g < width_height; g++) begin : g_addr
    assign rd_addr[8*g +: 8] = lane_addr[g];
  end

  assign dbg_state = state;

endmodule

// File: doc/mem_rd_skew_ctrl.md
Name: mem_rd_skew_ctrl

Overview:
- Read sequencer that sits directly upstream of the per-lane input memory array.
- Drives that array's per-lane read-enable and read-address buses so that row k of a tile comes out diagonally skewed: lane i reads one cycle after lane i-1. This is the skew the systolic array's west edge expects.
- Also produces a per-lane data-valid strobe that is aligned to the memory's 1-cycle read latency.

Parameters:
- width_height, 4, number of lanes (memory banks / array rows); each lane has an 8-bit address.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a tile read; sampled only in IDLE.
- base_addr  input  8  first row address, shared by all lanes; captured on accepted start.
- num_rows  input  8  number of rows per lane (0..255); captured on accepted start.
- rd_en  output  width_height  per-lane read enable; connects to the memory array's rd_en.
- rd_addr  output  width_height*8  lane i occupies bits [8i+7:8i]; connects to the memory array's rd_addr.
- rd_valid  output  width_height  per-lane strobe: the memory rd_data lane is valid this cycle.
- busy  output  1  high while a tile read is in progress.
- done  output  1  one-cycle pulse when the tile read completes.

Behaviour:
- All outputs are registered.
- Reset values: rd_en=0, rd_addr=0, rd_valid=0, busy=0, done=0, state=IDLE, row counter=0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE: start=1 and num_rows!=0.
  - ISSUE -> DRAIN: after lane 0 has issued num_rows reads.
  - DRAIN -> IDLE: in the cycle the last rd_valid of lane width_height-1 is driven; done=1 that cycle.
- Timing, with start accepted at cycle T and N=num_rows:
  - Lane 0: rd_en=1 for cycles T+1..T+N, addr = base_addr+k at cycle T+1+k.
  - Lane i: exact copy of lane i-1 delayed one cycle (rd_en and address, via a per-lane shift register). Active T+1+i..T+N+i.
  - rd_valid[i] = rd_en[i] delayed one cycle.
  - Last rd_valid[W-1] (W=width_height) occurs at T+N+W; done pulses in that same cycle.
  - busy=1 for cycles T+1..T+N+W inclusive; busy=0 in the cycle after done.
- Address arithmetic: 8-bit, modulo 256. base_addr+k wraps from 255 to 0 with no flag.
- When a lane is not enabled, its rd_addr holds its last value. Lane 0 holds its final address after ISSUE ends; lane i follows the shift.
- start while busy (ISSUE or DRAIN): ignored. base_addr and num_rows are not re-sampled.
- start with num_rows=0 in IDLE: no reads; busy stays 0; done pulses at T+1.
- start in the same cycle as done: ignored; FSM returns to IDLE, and a new start must arrive on a later cycle.
- reset mid-operation: at the next edge all outputs clear and state=IDLE; no done pulse. Shift registers and the counter are also cleared, so no residual rd_en appears.
- Latency from start to first lane-0 rd_en: 1 cycle. Throughput: one tile every N+W+1 cycles, back-to-back.

Test Plan:
- Reset then idle: hold reset 2 cycles, release, start=0 for 10 cycles -> rd_en=0, rd_valid=0, busy=0, done=0, rd_addr=0 throughout.
- Basic skew (W=4): base_addr=0x10, N=3, start at T.
  - Lane 0: rd_en at T+1..T+3, addr 0x10,0x11,0x12.
  - Lane 3: rd_en at T+4..T+6, same addresses.
  - rd_valid[3] at T+5..T+7; done at T+7; busy at T+1..T+7.
- Wrap-around: base_addr=0xFE, N=4 -> lane 0 addresses 0xFE,0xFF,0x00,0x01; each other lane shows the same sequence delayed i cycles.
- Ignored start: start pulses at T+2 and at done cycle with base_addr=0x80 -> no extra rd_en and no second done. Then a start 2 cycles after done runs cleanly from 0x80.
- Zero rows: N=0, start at T -> done=1 at T+1 only; rd_en, rd_valid and busy stay 0.
- Reset mid-run: N=8, assert reset at T+5 for 1 cycle -> from T+6 all outputs are 0 and state is IDLE, with no done. A fresh start afterwards behaves exactly as the basic skew case.
